// File: rtl/register_file_mp.sv
// Multi-port integer register file with two prioritised write ports, optional
// write-to-read bypass, hardwired zero register and a per-register busy scoreboard.
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           RegWrite0,
    input  logic [ADDR_WIDTH-1:0]          WriteRegister0,
    input  logic [DATA_WIDTH-1:0]          RegWriteData0,
    input  logic                           RegWrite1,
    input  logic [ADDR_WIDTH-1:0]          WriteRegister1,
    input  logic [DATA_WIDTH-1:0]          RegWriteData1,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
    input  logic                           ReserveEn,
    input  logic [ADDR_WIDTH-1:0]          ReserveRegister,
    output logic [NUM_READ-1:0]            Busy,
    output logic                           WriteConflict
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic                  r_conflict;

    logic                  w_we0;
    logic                  w_we1;
    logic                  w_res;
    logic [DEPTH-1:0]      w_busyNext;

    // Effective enables: anything aimed at a hardwired zero register is dropped here.
    assign w_we0 = RegWrite0 && !((ZERO_REG != 0) && (WriteRegister0 == '0));
    assign w_we1 = RegWrite1 && !((ZERO_REG != 0) && (WriteRegister1 == '0));
    assign w_res = ReserveEn && !((ZERO_REG != 0) && (ReserveRegister == '0));

    // Set is applied after clears so a newer producer's reservation survives a retiring write.
    always_comb begin
        w_busyNext = r_busy;
        if (w_we0) begin
            w_busyNext[WriteRegister0] = 1'b0;
        end
        if (w_we1) begin
            w_busyNext[WriteRegister1] = 1'b0;
        end
        if (w_res) begin
            w_busyNext[ReserveRegister] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (w_we0) begin
                r_regs[WriteRegister0] <= RegWriteData0;
            end
            if (w_we1) begin
                r_regs[WriteRegister1] <= RegWriteData1;
            end
            r_busy     <= w_busyNext;
            r_conflict <= w_we0 && w_we1 && (WriteRegister0 == WriteRegister1);
        end
    end

    assign WriteConflict = r_conflict;

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_idx;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_busy;
        logic                  w_hit0;
        logic                  w_hit1;
        logic                  w_hitRes;

        assign w_idx    = ReadRegister[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_hit0   = w_we0 && (WriteRegister0 == w_idx);
        assign w_hit1   = w_we1 && (WriteRegister1 == w_idx);
        assign w_hitRes = w_res && (ReserveRegister == w_idx);

        always_comb begin
            w_data = r_regs[w_idx];
            w_busy = r_busy[w_idx];
            if (BYPASS != 0) begin
                if (w_hit1) begin
                    w_data = RegWriteData1;
                end else if (w_hit0) begin
                    w_data = RegWriteData0;
                end
                if ((w_hit0 || w_hit1) && !w_hitRes) begin
                    w_busy = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (w_idx == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign ReadData[g*DATA_WIDTH +: DATA_WIDTH] = reset ? '0 : w_data;
        assign Busy[g]                              = reset ? 1'b0 : w_busy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: one instance with zero register and bypass,
// one without either, both driven by the same stimulus and checked against a bench model.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite0, RegWrite1, ReserveEn;
    logic [4:0]  WriteRegister0, WriteRegister1, ReserveRegister;
    logic [31:0] RegWriteData0, RegWriteData1;
    logic [9:0]  ReadRegister;
    logic [63:0] rdA, rdB;
    logic [1:0]  busyA, busyB;
    logic        confA, confB;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [63:0] rd0, rd1;
        logic [1:0]  bz0, bz1;
        logic        cf0, cf1;
    } exp_t;

    exp_t expQ[$];

    logic [31:0] mMem  [2][32];
    logic        mBusy [2][32];
    logic        mConf [2];
    int          zrCfg [2] = '{1, 0};
    int          bpCfg [2] = '{1, 0};

    always #5 clk = ~clk;

    register_file_mp #(.ZERO_REG(1), .BYPASS(1)) dutA (
        .clk(clk), .reset(reset),
        .RegWrite0(RegWrite0), .WriteRegister0(WriteRegister0), .RegWriteData0(RegWriteData0),
        .RegWrite1(RegWrite1), .WriteRegister1(WriteRegister1), .RegWriteData1(RegWriteData1),
        .ReadRegister(ReadRegister), .ReadData(rdA),
        .ReserveEn(ReserveEn), .ReserveRegister(ReserveRegister),
        .Busy(busyA), .WriteConflict(confA)
    );

    register_file_mp #(.ZERO_REG(0), .BYPASS(0)) dutB (
        .clk(clk), .reset(reset),
        .RegWrite0(RegWrite0), .WriteRegister0(WriteRegister0), .RegWriteData0(RegWriteData0),
        .RegWrite1(RegWrite1), .WriteRegister1(WriteRegister1), .RegWriteData1(RegWriteData1),
        .ReadRegister(ReadRegister), .ReadData(rdB),
        .ReserveEn(ReserveEn), .ReserveRegister(ReserveRegister),
        .Busy(busyB), .WriteConflict(confB)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void modelRead(input int k, input logic [4:0] idx,
                                      output logic [31:0] d, output logic b);
        logic e0, e1, er;
        e0 = RegWrite0 && !(zrCfg[k] != 0 && WriteRegister0 == 5'd0);
        e1 = RegWrite1 && !(zrCfg[k] != 0 && WriteRegister1 == 5'd0);
        er = ReserveEn && !(zrCfg[k] != 0 && ReserveRegister == 5'd0);
        d  = mMem[k][idx];
        b  = mBusy[k][idx];
        if (bpCfg[k] != 0) begin
            if (e1 && WriteRegister1 == idx) d = RegWriteData1;
            else if (e0 && WriteRegister0 == idx) d = RegWriteData0;
            if (((e0 && WriteRegister0 == idx) || (e1 && WriteRegister1 == idx)) &&
                !(er && ReserveRegister == idx)) b = 1'b0;
        end
        if (zrCfg[k] != 0 && idx == 5'd0) begin
            d = 32'd0;
            b = 1'b0;
        end
        if (reset) begin
            d = 32'd0;
            b = 1'b0;
        end
    endfunction

    function automatic void modelEdge();
        logic e0, e1, er;
        for (int k = 0; k < 2; k++) begin
            e0 = RegWrite0 && !(zrCfg[k] != 0 && WriteRegister0 == 5'd0);
            e1 = RegWrite1 && !(zrCfg[k] != 0 && WriteRegister1 == 5'd0);
            er = ReserveEn && !(zrCfg[k] != 0 && ReserveRegister == 5'd0);
            if (reset) begin
                for (int r = 0; r < 32; r++) begin
                    mMem[k][r]  = 32'd0;
                    mBusy[k][r] = 1'b0;
                end
                mConf[k] = 1'b0;
            end else begin
                if (e0) mMem[k][WriteRegister0] = RegWriteData0;
                if (e1) mMem[k][WriteRegister1] = RegWriteData1;
                if (e0) mBusy[k][WriteRegister0] = 1'b0;
                if (e1) mBusy[k][WriteRegister1] = 1'b0;
                if (er) mBusy[k][ReserveRegister] = 1'b1;
                mConf[k] = e0 && e1 && (WriteRegister0 == WriteRegister1);
            end
        end
    endfunction

    // Drive one cycle, queue the model's prediction, compare at the falling edge, then advance.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic rsv, input logic [4:0] rsr);
        exp_t        e;
        exp_t        got;
        logic [31:0] d0, d1;
        logic        b0, b1;
        reset = rst;
        RegWrite0 = we0; WriteRegister0 = wa0; RegWriteData0 = wd0;
        RegWrite1 = we1; WriteRegister1 = wa1; RegWriteData1 = wd1;
        ReadRegister = {ra1, ra0};
        ReserveEn = rsv; ReserveRegister = rsr;
        e.tag = tag;
        modelRead(0, ra0, d0, b0); modelRead(0, ra1, d1, b1);
        e.rd0 = {d1, d0}; e.bz0 = {b1, b0}; e.cf0 = mConf[0];
        modelRead(1, ra0, d0, b0); modelRead(1, ra1, d1, b1);
        e.rd1 = {d1, d0}; e.bz1 = {b1, b0}; e.cf1 = mConf[1];
        expQ.push_back(e);
        @(negedge clk);
        checkOutput({tag, "/qlen"}, 64'(expQ.size()), 64'd1);
        if (expQ.size() > 0) begin
            got = expQ.pop_front();
            checkOutput({got.tag, "/A.rd"},   rdA,          got.rd0);
            checkOutput({got.tag, "/A.busy"}, 64'(busyA),   64'(got.bz0));
            checkOutput({got.tag, "/A.conf"}, 64'(confA),   64'(got.cf0));
            checkOutput({got.tag, "/B.rd"},   rdB,          got.rd1);
            checkOutput({got.tag, "/B.busy"}, 64'(busyB),   64'(got.bz1));
            checkOutput({got.tag, "/B.conf"}, 64'(confB),   64'(got.cf1));
        end
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                mMem[k][r]  = 32'hx;
                mBusy[k][r] = 1'bx;
            end
            mConf[k] = 1'bx;
        end
        @(posedge clk);
        #1;
        applyStimulus("rst0",     1, 0,0,0,          0,0,0,          0,1,    0,0);
        applyStimulus("rst1",     1, 0,0,0,          0,0,0,          1,31,   0,0);
        applyStimulus("idle",     0, 0,0,0,          0,0,0,          31,0,   0,0);
        applyStimulus("wr x1",    0, 1,1,32'd2,      0,0,0,          1,2,    0,0);
        applyStimulus("rd x1",    0, 0,0,0,          0,0,0,          1,1,    0,0);
        applyStimulus("wr x0",    0, 1,0,32'd2,      0,0,0,          0,1,    0,0);
        applyStimulus("rd x0",    0, 0,0,0,          0,0,0,          0,0,    0,0);
        applyStimulus("byp x5",   0, 1,5,32'hDEADBEEF, 0,0,0,        5,5,    0,0);
        applyStimulus("rd x5",    0, 0,0,0,          0,0,0,          5,1,    0,0);
        applyStimulus("coll x7",  0, 1,7,32'h11,     1,7,32'h22,     7,7,    0,0);
        applyStimulus("conf1",    0, 0,0,0,          0,0,0,          7,5,    0,0);
        applyStimulus("conf0",    0, 0,0,0,          0,0,0,          7,0,    0,0);
        applyStimulus("coll x0",  0, 1,0,32'h33,     1,0,32'h44,     0,7,    0,0);
        applyStimulus("coll x0b", 0, 0,0,0,          0,0,0,          0,0,    0,0);
        applyStimulus("rsv x3",   0, 0,0,0,          0,0,0,          3,3,    1,3);
        applyStimulus("busy x3",  0, 0,0,0,          0,0,0,          3,3,    0,0);
        applyStimulus("clr x3",   0, 1,3,32'h3,      0,0,0,          3,1,    0,0);
        applyStimulus("idle x3",  0, 0,0,0,          0,0,0,          3,3,    0,0);
        applyStimulus("rsvwr x4", 0, 1,4,32'h4,      0,0,0,          4,4,    1,4);
        applyStimulus("busy x4",  0, 0,0,0,          0,0,0,          4,3,    0,0);
        applyStimulus("rsv x0",   0, 0,0,0,          0,0,0,          0,4,    1,0);
        applyStimulus("busy x0",  0, 0,0,0,          0,0,0,          0,0,    0,0);
        applyStimulus("set x2",   0, 1,2,32'd9,      0,0,0,          2,4,    1,2);
        applyStimulus("rstwr x2", 1, 1,2,32'd5,      0,0,0,          2,4,    1,5);
        applyStimulus("post x2",  0, 0,0,0,          0,0,0,          2,4,    0,0);
        for (int n = 0; n < 60; n++) begin
            applyStimulus("rand", ($urandom_range(0, 15) == 0),
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom), 5'($urandom_range(0, 7)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port integer register file for the five-stage RISC-V pipeline. Replaces the single-write, two-read register file.
- Adds the following over that block:
  - configurable width, depth and read-port count;
  - two write ports with fixed priority;
  - write-to-read bypass;
  - a hardwired-zero register;
  - a per-register busy scoreboard for ID-stage hazard detection.
- ID reads operands from it. WB (port 0) and a late-result path (port 1) write it.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width. DEPTH = 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1. When 1, register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1. When 1, same-cycle write data and busy-clear are forwarded to read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWrite0  in  1  write enable, port 0.
- WriteRegister0  in  ADDR_WIDTH  write index, port 0.
- RegWriteData0  in  DATA_WIDTH  write data, port 0.
- RegWrite1  in  1  write enable, port 1 (priority port).
- WriteRegister1  in  ADDR_WIDTH  write index, port 1.
- RegWriteData1  in  DATA_WIDTH  write data, port 1.
- ReadRegister  in  NUM_READ*ADDR_WIDTH  read indices; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- ReadData  out  NUM_READ*DATA_WIDTH  read data, same slicing.
- ReserveEn  in  1  mark ReserveRegister busy (instruction issued with destination).
- ReserveRegister  in  ADDR_WIDTH  register to mark busy.
- Busy  out  NUM_READ  busy flag of each read port's register.
- WriteConflict  out  1  registered pulse: both ports wrote the same effective register last cycle.

Behaviour:

Reset:
- When reset is high at a rising edge, all DEPTH registers become 0, all busy bits clear and WriteConflict becomes 0.
- Reset dominates any write or reserve in that cycle.
- While reset is high, ReadData and Busy are forced to 0 combinationally.

Writes:
- A write takes effect at the rising edge when its RegWrite is high.
- If both ports target the same register in the same cycle, port 1's data is stored.
- With ZERO_REG=1, writes to index 0 are discarded and do not count as conflicts.

Reads:
- Reads are combinational, with zero latency from ReadRegister to ReadData.
- With ZERO_REG=1, index 0 returns 0.
- With BYPASS=1, a read whose index matches an active same-cycle write returns that write's data instead of stored data. Port 1 wins if both ports match.
- With BYPASS=0, the read returns the stored (pre-edge) value.

Scoreboard:
- One busy bit per register.
- At the edge, ReserveEn sets busy[ReserveRegister].
- A write on either port clears busy[WriteRegister] at the same edge.
- If a reserve and a write target the same register in the same cycle, busy ends set, because the reservation belongs to a newer producer.
- With ZERO_REG=1, reserving index 0 is ignored.
- Busy[i] is the current busy bit of ReadRegister slice i.
- With BYPASS=1, Busy[i] reads 0 if a same-cycle write clears that register, unless a same-cycle reserve targets it.

WriteConflict:
- Registered; asserts for exactly one cycle after an edge at which both RegWrite0 and RegWrite1 were high with equal effective (non-discarded) indices.

Simultaneous events:
- Multiple read ports may address the same register; each returns an identical value.
- Reading and writing the same index in a cycle follows the BYPASS rule above.

Test Plan:
1. Reset for 2 cycles, then read indices 0, 1 and 31 -> ReadData=0 and Busy=0 on all ports.
2. Port 0 writes x1=2 at edge 1; the next cycle reads x1 on port 0 -> 2. Writing x0=2 then reading x0 -> 0 with ZERO_REG=1, and 2 with ZERO_REG=0.
3. Bypass: in the same cycle, write x5=0xDEADBEEF and read x5. BYPASS=1 -> 0xDEADBEEF before the edge; BYPASS=0 -> old value 0.
4. Dual write collision: port 0 writes x7=0x11 and port 1 writes x7=0x22 at the same edge. Required response:
   - x7 reads 0x22;
   - WriteConflict=1 for exactly one cycle;
   - a same-cycle bypassed read of x7 shows 0x22.
5. Scoreboard:
   - ReserveEn with x3 -> Busy=1 on any port reading x3.
   - A port 0 write to x3 clears it (Busy=0 after the edge; same cycle with BYPASS=1).
   - Reserve x4 and write x4 in the same cycle -> Busy stays 1.
6. Reset mid-operation: with x2=9 and x2 busy, assert reset in the same cycle as a write of x2=5 -> after the edge, x2 reads 0 and Busy=0.
